// File: rtl/zap_wb_sram_ctrl.sv
// Wishbone B3 slave that drives a single-port synchronous SRAM (1-cycle read latency).
// Classic cycles use programmable wait states; zero-wait linear read bursts stream one beat per cycle.
module zap_wb_sram_ctrl #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic [31:0]           i_wb_adr,
    input  logic                  i_wb_we,
    input  logic [3:0]            i_wb_sel,
    input  logic [31:0]           i_wb_dat,
    input  logic [2:0]            i_wb_cti,
    input  logic [1:0]            i_wb_bte,
    output logic                  o_wb_ack,
    output logic [31:0]           o_wb_dat,
    output logic                  o_ram_en,
    output logic [3:0]            o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_adr,
    output logic [31:0]           o_ram_wdat,
    input  logic [31:0]           i_ram_rdat
);
    localparam logic [2:0] CTI_INCR  = 3'b010;
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

    state_t                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic                  req;
    logic                  fast_path;
    logic [ADDR_WIDTH-1:0] adr_word;
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic [3:0]            bus_we;
    logic                  unused_adr_bits;

    assign req       = i_wb_cyc & i_wb_stb;
    assign adr_word  = i_wb_adr[ADDR_WIDTH+1:2];
    assign ptr_inc   = ptr_q + 1'b1;
    assign bus_we    = i_wb_we ? i_wb_sel : 4'b0000;
    assign fast_path = ZERO_WAIT && !i_wb_we && (i_wb_cti == CTI_INCR) && (i_wb_bte == 2'b00);

    // Upper and byte-lane address bits alias by design.
    assign unused_adr_bits = ^{i_wb_adr[31:ADDR_WIDTH+2], i_wb_adr[1:0]};

    assign o_wb_dat   = i_ram_rdat;
    assign o_ram_wdat = i_wb_dat;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        ptr_d     = ptr_q;
        o_wb_ack  = 1'b0;
        o_ram_en  = 1'b0;
        o_ram_we  = 4'b0000;
        o_ram_adr = adr_word;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (ZERO_WAIT) begin
                        o_ram_en = 1'b1;
                        o_ram_we = bus_we;
                        ptr_d    = adr_word;
                        state_d  = fast_path ? S_BURST : S_ACK;
                    end else begin
                        wcnt_d  = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    o_ram_en = 1'b1;
                    o_ram_we = bus_we;
                    state_d  = S_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACK: begin
                o_wb_ack = 1'b1;
                state_d  = S_IDLE;
            end
            S_BURST: begin
                // Any deviation from the predicted beat drops the speculative read; IDLE re-serves it.
                if (req && !i_wb_we && (adr_word == ptr_q)) begin
                    o_wb_ack = 1'b1;
                    if (i_wb_cti == CTI_INCR) begin
                        o_ram_en  = 1'b1;
                        o_ram_adr = ptr_inc;
                        ptr_d     = ptr_inc;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!i_reset_n) begin
            o_wb_ack = 1'b0;
            o_ram_en = 1'b0;
            o_ram_we = 4'b0000;
        end
    end
endmodule

// File: tb/tb_zap_wb_sram_ctrl.sv
// Bench for zap_wb_sram_ctrl: four instances (W=0/AW=14, W=3/AW=6, W=5/AW=6, W=0/AW=4), each on its own RAM model.
// Read expectations are queued when a beat is driven and popped when the DUT acks it.
module tb_zap_wb_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_init;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    int          dut_sel;

    logic        ack_a  [4];
    logic [31:0] rdo_a  [4];
    logic        en_a   [4];
    logic [3:0]  rwe_a  [4];
    logic [13:0] radr_a [4];
    logic [31:0] wdat_a [4];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ack, n_act;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [10];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int AW = (gi == 0) ? 14 : (gi == 3) ? 4 : 6;
        localparam int WS = (gi == 1) ? 3 : (gi == 2) ? 5 : 0;
        logic [AW-1:0] ram_adr;
        logic [31:0]   ram_rdat;
        logic [31:0]   mem [0:(1<<AW)-1];

        zap_wb_sram_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_dut (
            .i_clk      (clk),
            .i_reset_n  (rst_n),
            .i_wb_cyc   (cyc && (dut_sel == gi)),
            .i_wb_stb   (stb && (dut_sel == gi)),
            .i_wb_adr   (adr),
            .i_wb_we    (we),
            .i_wb_sel   (sel),
            .i_wb_dat   (dat),
            .i_wb_cti   (cti),
            .i_wb_bte   (bte),
            .o_wb_ack   (ack_a[gi]),
            .o_wb_dat   (rdo_a[gi]),
            .o_ram_en   (en_a[gi]),
            .o_ram_we   (rwe_a[gi]),
            .o_ram_adr  (ram_adr),
            .o_ram_wdat (wdat_a[gi]),
            .i_ram_rdat (ram_rdat)
        );
        assign radr_a[gi] = 14'(ram_adr);

        // Word i of every RAM is preloaded with value i.
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'(i);
            end else if (en_a[gi]) begin
                for (int b = 0; b < 4; b++)
                    if (rwe_a[gi][b]) mem[ram_adr][8*b +: 8] <= wdat_a[gi][8*b +: 8];
                ram_rdat <= mem[ram_adr];
            end
        end
    end

    function automatic logic [31:0] word_mask(input int aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got 0x%08h with no expected entry queued", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat = '0; cti = 3'b000; bte = 2'b00;
    endtask

    task automatic classic(input int d, input int aw, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] wd, input logic [31:0] exp_rd,
                           input int lat, input string tag);
        int          k_ack, k_en, n_we;
        logic [3:0]  we_seen;
        logic [13:0] adr_seen;
        k_ack = -1; k_en = -1; n_we = 0; we_seen = '0; adr_seen = '0;
        dut_sel = d; cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = wd;
        cti = 3'b000; bte = 2'b00;
        if (!w) exp_q.push_back(exp_rd);
        for (int k = 0; k < 40 && k_ack < 0; k++) begin
            @(negedge clk);
            if (en_a[d] && k_en < 0) begin
                k_en = k;
                adr_seen = radr_a[d];
            end
            if (rwe_a[d] != 4'b0000) begin
                n_we++;
                we_seen = rwe_a[d];
            end
            if (ack_a[d]) begin
                k_ack = k;
                if (!w) pop_check({tag, " rdata"}, rdo_a[d]);
            end
            @(posedge clk); #1;
        end
        bus_idle();
        check({tag, " ack_lat"}, 32'(k_ack), 32'(lat));
        check({tag, " en_cyc"}, 32'(k_en), 32'(lat - 1));
        check({tag, " ram_adr"}, 32'(adr_seen), (a >> 2) & word_mask(aw));
        check({tag, " we_cycles"}, 32'(n_we), (w && s != 4'h0) ? 32'd1 : 32'd0);
        if (w) check({tag, " we_bits"}, 32'(we_seen), 32'(s));
        $display("txn %s: %s adr=0x%08h ack after %0d cycles", tag, w ? "write" : "read", a, k_ack);
    endtask

    task automatic burst(input int d, input int aw, input logic [31:0] a0, input int nb,
                         input logic [1:0] bt, input int lat0, input int latn, input int abort_after,
                         input int jump_beat, input logic [31:0] jump_adr, input int jump_lat,
                         input string tag);
        logic [31:0] a;
        int          k_ack, exp_lat;
        logic        en_last;
        a = a0; en_last = 1'b0;
        dut_sel = d; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; dat = '0; bte = bt;
        for (int b = 0; b < nb; b++) begin
            if (b == abort_after) begin
                bus_idle();
                n_ack = 0; n_act = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (ack_a[d]) n_ack++;
                    if (en_a[d] || rwe_a[d] != 4'b0000) n_act++;
                    @(posedge clk); #1;
                end
                check({tag, " abort_acks"}, 32'(n_ack), 32'd0);
                check({tag, " abort_ram_ops"}, 32'(n_act), 32'd0);
                $display("txn %s: burst aborted after %0d beats", tag, b);
                return;
            end
            if (b == jump_beat) a = jump_adr;
            adr = a;
            cti = (b == nb - 1) ? 3'b111 : 3'b010;
            exp_q.push_back((a >> 2) & word_mask(aw));
            exp_lat = (b == 0) ? lat0 : (b == jump_beat) ? jump_lat : latn;
            k_ack = -1;
            for (int k = 0; k < 40 && k_ack < 0; k++) begin
                @(negedge clk);
                if (ack_a[d]) begin
                    k_ack = k;
                    en_last = en_a[d];
                    pop_check($sformatf("%s beat%0d rdata", tag, b), rdo_a[d]);
                end
                @(posedge clk); #1;
            end
            check($sformatf("%s beat%0d lat", tag, b), 32'(k_ack), 32'(exp_lat));
            a = a + 32'd4;
        end
        bus_idle();
        check({tag, " en_last_beat"}, 32'(en_last), 32'd0);
        @(negedge clk);
        check({tag, " idle_ack"}, 32'(ack_a[d]), 32'd0);
        check({tag, " idle_en"}, 32'(en_a[d]), 32'd0);
        @(posedge clk); #1;
        $display("txn %s: burst of %0d beats from 0x%08h", tag, nb, a0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vt[1] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF};
        vt[2] = '{1'b1, 32'h0000_0010, 4'h2, 32'h0000_AB00, 32'h0};
        vt[3] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_ABEF};
        vt[4] = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'h0000_0005};
        vt[5] = '{1'b1, 32'h0000_0020, 4'h9, 32'h1122_3344, 32'h0};
        vt[6] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h1100_0044};
        vt[7] = '{1'b0, 32'h0001_0020, 4'hF, 32'h0,         32'h1100_0044};
        vt[8] = '{1'b1, 32'h0000_0024, 4'h0, 32'hFFFF_FFFF, 32'h0};
        vt[9] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         32'h0000_0009};

        // Reset with a live write request on instance 0: nothing may reach the bus or RAM.
        rst_n = 1'b0; mem_init = 1'b1; bus_idle(); dut_sel = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; sel = 4'hF; dat = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                check($sformatf("reset ack d%0d", d), 32'(ack_a[d]), 32'd0);
                check($sformatf("reset en d%0d", d), 32'(en_a[d]), 32'd0);
                check($sformatf("reset we d%0d", d), 32'(rwe_a[d]), 32'd0);
            end
        end
        @(posedge clk); #1;
        bus_idle(); mem_init = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            classic(0, 14, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, vt[i].exp_rd, 1,
                    $sformatf("vec%0d", i));

        burst(0, 14, 32'h100, 16, 2'b00, 1, 0, -1, -1, 32'h0, 0, "u0 linear16");
        classic(0, 14, 1'b0, 32'h14, 4'hF, 32'h0, 32'h5, 1, "u0 after burst");
        burst(0, 14, 32'h200, 4, 2'b10, 1, 1, -1, -1, 32'h0, 0, "u0 wrapbte");
        burst(0, 14, 32'h100, 8, 2'b00, 1, 0, 3, -1, 32'h0, 0, "u0 abort");
        classic(0, 14, 1'b0, 32'h18, 4'hF, 32'h0, 32'h6, 1, "u0 after abort");
        burst(0, 14, 32'h100, 6, 2'b00, 1, 0, -1, 3, 32'h200, 2, "u0 skip");

        classic(1, 6, 1'b0, 32'h10, 4'hF, 32'h0, 32'h4, 4, "u3 read");
        burst(1, 6, 32'h40, 4, 2'b00, 4, 4, -1, -1, 32'h0, 0, "u3 burst");

        burst(3, 4, 32'h3C, 2, 2'b00, 1, 0, -1, -1, 32'h0, 0, "u4 wrap");

        // Reset pulse while instance 2 (W=5) waits on a write.
        dut_sel = 2; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; sel = 4'hF;
        dat = 32'hFFFF_FFFF; cti = 3'b000; bte = 2'b00;
        n_ack = 0; n_act = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) rst_n = 1'b0;
            @(negedge clk);
            if (ack_a[2]) n_ack++;
            if (rwe_a[2] != 4'b0000) n_act++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1; bus_idle();
        @(negedge clk);
        check("post-reset ack", 32'(ack_a[2]), 32'd0);
        check("post-reset en", 32'(en_a[2]), 32'd0);
        check("post-reset we", 32'(rwe_a[2]), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack_a[2]) n_ack++;
            if (rwe_a[2] != 4'b0000) n_act++;
            @(posedge clk); #1;
        end
        check("reset-abort acks", 32'(n_ack), 32'd0);
        check("reset-abort writes", 32'(n_act), 32'd0);
        $display("txn u5 write aborted by reset");
        classic(2, 6, 1'b0, 32'h8, 4'hF, 32'h0, 32'h2, 6, "u5 post-reset read");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
